// File: rtl/aes_decipher_block.sv
`default_nettype none
// ============================================================================
//  Module   : aes_decipher_block
//  Purpose  : Iterative AES-128 inverse cipher. One INIT round, then ten
//             rounds of four single-word inverse S-box cycles plus one
//             key-mixing cycle. Round keys are fetched by the round index.
//  Revision : 1.0  initial release
// ============================================================================
module aes_decipher_block (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_SBOX = 2'd2,
      ST_MAIN = 2'd3
   } fsm_t;

   fsm_t        fsm;
   logic [31:0] w0, w1, w2, w3;
   logic [3:0]  round_ctr;
   logic [1:0]  sword_ctr;

   // Multiply by x in GF(2^8) modulo 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply a byte by a 4-bit constant, built from x, x^2 and x^3 multiples.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
   endfunction

   // Inverse MixColumns on a single column; byte 31:24 is row 0.
   function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = w;
      return {gf_mul(b0, 4'he) ^ gf_mul(b1, 4'hb) ^ gf_mul(b2, 4'hd) ^ gf_mul(b3, 4'h9),
              gf_mul(b0, 4'h9) ^ gf_mul(b1, 4'he) ^ gf_mul(b2, 4'hb) ^ gf_mul(b3, 4'hd),
              gf_mul(b0, 4'hd) ^ gf_mul(b1, 4'h9) ^ gf_mul(b2, 4'he) ^ gf_mul(b3, 4'hb),
              gf_mul(b0, 4'hb) ^ gf_mul(b1, 4'hd) ^ gf_mul(b2, 4'h9) ^ gf_mul(b3, 4'he)};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
              inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
   endfunction

   // Inverse ShiftRows: row r of the state rotates right by r columns.
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [31:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = s;
      return {a0[31:24], a3[23:16], a2[15:8], a1[7:0],
              a1[31:24], a0[23:16], a3[15:8], a2[7:0],
              a2[31:24], a1[23:16], a0[15:8], a3[7:0],
              a3[31:24], a2[23:16], a1[15:8], a0[7:0]};
   endfunction

   assign round     = round_ctr;
   assign new_block = {w0, w1, w2, w3};

   // Present the word under substitution to the external inverse S-box.
   always_comb begin
      sboxw = 32'h0;
      if (fsm == ST_SBOX) begin
         case (sword_ctr)
            2'd0:    sboxw = w0;
            2'd1:    sboxw = w1;
            2'd2:    sboxw = w2;
            default: sboxw = w3;
         endcase
      end
   end

   // Round sequencing and state update; all outputs except sboxw are registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm       <= ST_IDLE;
         w0        <= 32'h0;
         w1        <= 32'h0;
         w2        <= 32'h0;
         w3        <= 32'h0;
         round_ctr <= 4'd0;
         sword_ctr <= 2'd0;
         ready     <= 1'b1;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (next) begin
                  round_ctr <= 4'd10;
                  ready     <= 1'b0;
                  fsm       <= ST_INIT;
               end
            end
            ST_INIT: begin
               {w0, w1, w2, w3} <= inv_shift(block ^ round_key);
               round_ctr        <= round_ctr - 4'd1;
               sword_ctr        <= 2'd0;
               fsm              <= ST_SBOX;
            end
            ST_SBOX: begin
               case (sword_ctr)
                  2'd0:    w0 <= new_sboxw;
                  2'd1:    w1 <= new_sboxw;
                  2'd2:    w2 <= new_sboxw;
                  default: w3 <= new_sboxw;
               endcase
               sword_ctr <= sword_ctr + 2'd1;
               if (sword_ctr == 2'd3) begin
                  fsm <= ST_MAIN;
               end
            end
            ST_MAIN: begin
               if (round_ctr != 4'd0) begin
                  {w0, w1, w2, w3} <= inv_shift(inv_mix({w0, w1, w2, w3} ^ round_key));
                  round_ctr        <= round_ctr - 4'd1;
                  sword_ctr        <= 2'd0;
                  fsm              <= ST_SBOX;
               end else begin
                  // Final AddRoundKey with key 0; round index stays at 0.
                  {w0, w1, w2, w3} <= {w0, w1, w2, w3} ^ round_key;
                  ready            <= 1'b1;
                  fsm              <= ST_IDLE;
               end
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_decipher_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_decipher_block
//  Purpose  : Self-checking bench for aes_decipher_block. Provides the round
//             key memory and inverse S-box, and checks plaintext against known
//             vectors and a forward-cipher reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_decipher_block;

   logic         clk;
   logic         reset_n;
   logic         next;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   int vectors;
   int miscompares;

   logic [7:0]   sbox   [256];
   logic [7:0]   inv_sb [256];
   logic [127:0] rk     [11];

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

   aes_decipher_block dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .round     (round),
      .round_key (round_key),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   // Key memory and inverse S-box, both combinational.
   assign round_key = (round <= 4'd10) ? rk[round] : 128'h0;
   assign new_sboxw = {inv_sb[sboxw[31:24]], inv_sb[sboxw[23:16]],
                       inv_sb[sboxw[15:8]],  inv_sb[sboxw[7:0]]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box from the field inverse followed by the affine transform.
   task automatic build_sboxes();
      logic [7:0] inv, b;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         if (a != 0)
            for (int x = 1; x < 256; x++)
               if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
         b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox[a]   = b;
         inv_sb[b] = 8'(a);
      end
   endtask

   task automatic set_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Forward AES-128 on a column-major byte array; byte index = row + 4*col.
   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] out;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[row+4*c] = s[row + 4*((c+row)%4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[r][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   // One decryption: start, follow edges E1..E51, check rounds, busy and result.
   task automatic run_op(input string name, input logic [127:0] ct, input logic [127:0] exp_pt,
                         input bit hold, input int pa, input int pb,
                         output logic [127:0] init_key);
      int         bad_round, early;
      logic [3:0] exp_r, bad_got, bad_exp;
      block = ct;
      next  = 1'b1;
      @(posedge clk); #1;
      if (!hold) next = 1'b0;
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_start: ready=%b expected 0 after E0", name, ready);
      end
      bad_round = 0; early = 0; init_key = 128'h0; bad_got = 4'h0; bad_exp = 4'h0;
      for (int e = 1; e <= 51; e++) begin
         exp_r = (e == 1) ? 4'd10 : 4'(9 - (e - 2) / 5);
         if (round !== exp_r) begin
            if (bad_round == 0) begin bad_got = round; bad_exp = exp_r; end
            bad_round++;
         end
         if (e == 1) init_key = round_key;
         @(posedge clk); #1;
         if (e < 51 && ready !== 1'b0) early++;
         if (!hold) next = ((e + 1) == pa) || ((e + 1) == pb);
      end
      vectors++;
      if (bad_round != 0) begin
         miscompares++;
         $display("FAIL %s_round_seq: %0d bad cycles, first got %0d expected %0d",
                  name, bad_round, bad_got, bad_exp);
      end
      vectors++;
      if (early != 0) begin
         miscompares++;
         $display("FAIL %s_busy: ready high on %0d edges before E51, expected 0", name, early);
      end
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_ready: ready=%b at E51 expected 1", name, ready);
      end
      vectors++;
      if (new_block !== exp_pt) begin
         miscompares++;
         $display("FAIL %s_plaintext: got %h expected %h", name, new_block, exp_pt);
      end
   endtask

   task automatic test_reset();
      int bad;
      reset_n = 1'b0; next = 1'b0; block = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (ready !== 1'b1 || new_block !== 128'h0 || round !== 4'd0 || sboxw !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_values: ready=%b block=%h round=%0d sboxw=%h expected 1/0/0/0",
                  ready, new_block, round, sboxw);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b1 || new_block !== 128'h0 || round !== 4'd0 || sboxw !== 32'h0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL idle_hold: outputs changed on %0d of 20 idle cycles, expected 0", bad);
      end
   endtask

   task automatic test_fips_c1();
      logic [127:0] k10;
      set_key(KEY_C1);
      run_op("c1", CT_C1, PT_C1, 1'b0, 0, 0, k10);
      vectors++;
      if (k10 !== RK10_C1) begin
         miscompares++;
         $display("FAIL c1_init_key: got %h expected %h", k10, RK10_C1);
      end
   endtask

   task automatic test_fips_b();
      logic [127:0] k10;
      set_key(KEY_B);
      run_op("fips_b", CT_B, PT_B, 1'b0, 0, 0, k10);
   endtask

   task automatic test_busy_next();
      logic [127:0] k10;
      int bad;
      set_key(KEY_C1);
      run_op("busy", CT_C1, PT_C1, 1'b0, 10, 30, k10);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b1 || new_block !== PT_C1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL busy_no_restart: %0d idle cycles disturbed, expected 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] k10;
      set_key(KEY_B);
      run_op("b2b_first", CT_B, PT_B, 1'b1, 0, 0, k10);
      run_op("b2b_second", model_encrypt(PT_C1), PT_C1, 1'b1, 0, 0, k10);
      next = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (ready !== 1'b1 || new_block !== PT_C1) begin
         miscompares++;
         $display("FAIL b2b_stop: ready=%b block=%h expected 1 and %h", ready, new_block, PT_C1);
      end
   endtask

   task automatic test_random();
      logic [127:0] key, pt, k10;
      for (int n = 0; n < 6; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         set_key(key);
         run_op("random", model_encrypt(pt), pt, 1'b0, 0, 0, k10);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] k10;
      set_key(KEY_C1);
      block = CT_C1;
      next  = 1'b1;
      @(posedge clk); #1;
      next = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b1 || new_block !== 128'h0 || round !== 4'd0 || sboxw !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid: ready=%b block=%h round=%0d sboxw=%h expected 1/0/0/0",
                  ready, new_block, round, sboxw);
      end
      #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (ready !== 1'b1 || new_block !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_mid_idle: ready=%b block=%h expected 1 and 0", ready, new_block);
      end
      run_op("after_reset", CT_C1, PT_C1, 1'b0, 0, 0, k10);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      next        = 1'b0;
      block       = 128'h0;
      for (int r = 0; r < 11; r++) rk[r] = 128'h0;
      build_sboxes();
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_busy_next();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES-128 inverse cipher datapath: takes a 128-bit ciphertext block and returns the plaintext after 10 decryption rounds. Round keys come from the shared key memory, indexed by the `round` output. Inverse S-box lookups are done one 32-bit word per cycle through an external inverse S-box. The block sits beside the encipher block under the AES core wrapper, which selects between the two by mode.

## Interface
- Parameters: none (AES-128 only, 10 rounds fixed).
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- next  in  1  start pulse or level, sampled only in IDLE.
- round  out  4  current round index; drives the round-key memory address.
- round_key  in  128  key for `round`, valid combinationally in the same cycle.
- sboxw  out  32  word presented to the inverse S-box; 0 when not in SBOX.
- new_sboxw  in  32  inverse-S-box result for `sboxw`, same cycle.
- block  in  128  ciphertext; must be stable in the INIT cycle.
- new_block  out  128  state register {w0,w1,w2,w3}; holds plaintext when ready=1 after an operation.
- ready  out  1  1 = idle / result valid.

## Operation
- State is four 32-bit word registers w0..w3 (w0 = bits 127:96). Each word is one column: byte 31:24 is row 0.
- inv_shiftrows rotates row r right by r:
  - ws0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]}
  - ws1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]}
  - ws2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]}
  - ws3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]}
- inv_mixcolumns, per word, over GF(2^8) mod 0x11b:
  - mb0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
  - mb1 = 09·b0 ^ 0e·b1 ^ 0b·b2 ^ 0d·b3
  - mb2 = 0d·b0 ^ 09·b1 ^ 0e·b2 ^ 0b·b3
  - mb3 = 0b·b0 ^ 0d·b1 ^ 09·b2 ^ 0e·b3
- Counters:
  - round_ctr, 4 bits: set to 10 on start, decremented; never wraps below 0.
  - sword_ctr, 2 bits: selects the word under S-box substitution.
- FSM states and transitions:
  - IDLE: on next=1, set round_ctr=10 and ready=0, go to INIT. Otherwise stay; no register changes.
  - INIT (round=10): state ← inv_shiftrows(block ^ round_key); round_ctr−1; sword_ctr=0; go to SBOX.
  - SBOX: sboxw = w[sword_ctr]; w[sword_ctr] ← new_sboxw; sword_ctr+1. After word 3, go to MAIN (4 cycles).
  - MAIN, round_ctr>0: state ← inv_shiftrows(inv_mixcolumns(state ^ round_key)); round_ctr−1; sword_ctr=0; go to SBOX.
  - MAIN, round_ctr==0: state ← state ^ round_key; ready=1; go to IDLE. round stays 0.
- Illegal FSM encodings fall back to IDLE with no update.

## Timing
- Reset values: state words 0, round 0, sword_ctr 0, ready 1, FSM IDLE, sboxw 0.
- Let edge E0 be the one that samples next=1 in IDLE.
  - ready=0 from E0 onward.
  - INIT is performed at E1.
  - The round sequence is 10 × (4 SBOX + 1 MAIN), on E2..E51.
  - The final MAIN at E51 loads the plaintext and sets ready=1.
  - Total latency is 51 edges after E0.
- `round` sequence as seen by the key memory: 10 (INIT), 9 ×5 cycles, …, 1 ×5, 0 ×5.
- next while ready=0 is ignored; there is no abort.
- next held high continuously restarts at E0 of the cycle after ready rises: IDLE lasts exactly one cycle.
- new_block changes only at INIT, SBOX and MAIN edges; it is stable while IDLE.
- reset_n low at any time: immediately returns to reset values; any partial result is discarded.

## Test plan
- Reset values: after reset, expect ready=1, new_block=0, round=0, sboxw=0. Hold next=0 for 20 cycles; no output changes.
- FIPS-197 App. C.1: key 000102…0f (bench key-schedule model driven by `round`), block=69c4e0d86a7b0430d8cdb78070b4c55a, next pulse → ready at E51, new_block=00112233445566778899aabbccddeeff. Also check that round_key seen at INIT is 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block=3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Also check the round sequence 10,9×5,…,0×5.
- Busy-state next: pulse next again at E10 and at E30 → no effect; same result at E51.
- Back-to-back: next held high across two operations with different blocks → second operation E0 is one cycle after the first ready; both results correct.
- Reset mid-operation: reset_n low at E25 → ready=1, new_block=0 immediately. A fresh operation afterwards gives the C.1 plaintext.
